// File: rtl/sme_match_arbiter_if.sv
// Bundle between the string-matcher result arbiter and its producer/consumer.
// slave = arbiter side, master = matcher/consumer side.
interface sme_match_arbiter_if #(
  parameter int LANES  = 8,
  parameter int IDX_W  = 16,
  parameter int STAT_W = 32
);
  localparam int LANE_W = $clog2(LANES);

  logic                   clear;
  logic [LANES*IDX_W-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [IDX_W-1:0]       match_index;
  logic [LANE_W-1:0]      match_lane;
  logic                   match_last;
  logic                   match_valid;
  logic                   match_ready;
  logic                   overflow;
  logic [STAT_W-1:0]      stat_matches;
  logic [STAT_W-1:0]      stat_drops;

  modport slave (
    input  clear, in_data, in_valid, match_ready,
    output in_ready, match_index, match_lane, match_last, match_valid,
           overflow, stat_matches, stat_drops
  );

  modport master (
    output clear, in_data, in_valid, match_ready,
    input  in_ready, match_index, match_lane, match_last, match_valid,
           overflow, stat_matches, stat_drops
  );
endinterface

// File: rtl/sme_match_arbiter.sv
// Buffers matcher result beats in a small FIFO and serialises non-zero indices, lowest lane first.
// Optional statistics counters are built only when SME_ARB_STATS_EN is defined.
module sme_match_arbiter #(
  parameter int LANES   = 8,
  parameter int IDX_W   = 16,
  parameter int FIFO_AW = 2,
  parameter int STAT_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  sme_match_arbiter_if.slave bus
);
  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int DW     = LANES * IDX_W;
  localparam int LANE_W = $clog2(LANES);

  logic [DW-1:0]      mem_q [DEPTH];
  logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0]      hold_data_q, hold_data_d;
  logic [LANES-1:0]   hold_mask_q, hold_mask_d;
  logic               overflow_q, overflow_d;

  logic               flush;
  logic               full, empty, beat_nz;
  logic               push, drop, accept, pop;
  logic [DW-1:0]      head_data;
  logic [LANES-1:0]   sel_onehot, mask_after;
  logic [LANE_W-1:0]  sel_lane;
  logic [IDX_W-1:0]   sel_index;
  logic               found, out_valid, out_last;

  // Handshakes: input beats are taken whenever in_valid is high (no back-pressure, in_ready is
  // advisory); an output index transfers on a cycle where match_valid and match_ready are both high.
  always_comb begin
    flush   = rst | bus.clear;
    beat_nz = |bus.in_data;
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
              (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    push    = !flush && bus.in_valid && beat_nz && !full;
    drop    = !flush && bus.in_valid && beat_nz && full;
  end

  always_comb begin
    sel_onehot = '0;
    sel_lane   = '0;
    sel_index  = '0;
    found      = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (!found && hold_mask_q[k]) begin
        found         = 1'b1;
        sel_onehot[k] = 1'b1;
        sel_lane      = LANE_W'(k);
        sel_index     = hold_data_q[k*IDX_W +: IDX_W];
      end
    end
    out_valid = |hold_mask_q;
    out_last  = out_valid && ((hold_mask_q & (hold_mask_q - LANES'(1))) == '0);
  end

  // The head beat is loaded as soon as the holding mask is (or is about to become) empty,
  // so indices from consecutive beats flow without a bubble.
  always_comb begin
    accept      = !flush && out_valid && bus.match_ready;
    mask_after  = hold_mask_q & ~(accept ? sel_onehot : '0);
    pop         = !flush && !empty && (mask_after == '0);
    head_data   = mem_q[rd_ptr_q[FIFO_AW-1:0]];
    hold_mask_d = mask_after;
    hold_data_d = hold_data_q;
    if (pop) begin
      hold_data_d = head_data;
      for (int k = 0; k < LANES; k++) begin
        hold_mask_d[k] = |head_data[k*IDX_W +: IDX_W];
      end
    end
    wr_ptr_d   = wr_ptr_q + (FIFO_AW+1)'(push);
    rd_ptr_d   = rd_ptr_q + (FIFO_AW+1)'(pop);
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      hold_data_q <= '0;
      hold_mask_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      hold_data_q <= hold_data_d;
      hold_mask_q <= hold_mask_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= bus.in_data;
    end
  end

  assign bus.in_ready    = !full;
  assign bus.match_valid = out_valid;
  assign bus.match_lane  = sel_lane;
  assign bus.match_index = sel_index;
  assign bus.match_last  = out_last;
  assign bus.overflow    = overflow_q;

`ifdef SME_ARB_STATS_EN
  logic [STAT_W-1:0] stat_matches_q, stat_drops_q;

  // Saturating counters: they stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (flush) begin
      stat_matches_q <= '0;
      stat_drops_q   <= '0;
    end else begin
      if (accept && !(&stat_matches_q)) stat_matches_q <= stat_matches_q + STAT_W'(1);
      if (drop && !(&stat_drops_q))     stat_drops_q   <= stat_drops_q + STAT_W'(1);
    end
  end

  assign bus.stat_matches = stat_matches_q;
  assign bus.stat_drops   = stat_drops_q;
`else
  assign bus.stat_matches = {STAT_W{1'b0}};
  assign bus.stat_drops   = {STAT_W{1'b0}};
`endif
endmodule
